btn_event_reader: RTL
=====================

# btn_event_reader

Input-side counterpart to the LED pattern shifter. Takes the raw active-low push button, synchronises and debounces it, and classifies each press as short or long. It emits single-cycle event pulses. It keeps a 6-bit press history in the same left-shift, LSB-insert form the LED shifter consumes, so the history can drive `led` directly or feed the shifter's input bit.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable synchronised samples required to accept a level change (10 ms at 27 MHz); legal range is 1 or more.
- `LONG_CYCLES`, default 27000000: cycles of accepted press after which the press is classed long (1 s at 27 MHz); must be greater than DEBOUNCE_CYCLES.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_n`, in, 1: raw button input, active-low, asynchronous to `clk`.
- `btn_level`, out, 1: debounced level; 1 means pressed.
- `press_pulse`, out, 1: one-cycle pulse on an accepted press.
- `long_pulse`, out, 1: one-cycle pulse when a press reaches the long threshold.
- `release_pulse`, out, 1: one-cycle pulse on an accepted release.
- `history`, out, 6: shifts left on each release; bit 0 takes 1 for a long press and 0 for a short press.
- `press_count`, out, 8: count of completed presses; wraps from 255 to 0.

## Operation
- **Synchroniser:** two flip-flops on `btn_n`, reset to 1 (the released value).
- **Debouncer**
  - One counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Each cycle the synchronised input differs from the stable level, the counter increments. When it equals the stable level, the counter clears.
  - The stable level flips when the counter reaches DEBOUNCE_CYCLES. The counter clears on the flip.
  - Any bounce restarts the count.
- **FSM states:** IDLE, PRESSED, LONG.
  - IDLE → PRESSED on a stable flip to pressed. `press_pulse` = 1.
  - PRESSED → LONG when the hold counter reaches LONG_CYCLES. `long_pulse` = 1.
  - PRESSED → IDLE on a stable flip to released.
    - `release_pulse` = 1.
    - `history` becomes {history[4:0], 0}.
    - `press_count` increments by 1.
  - LONG → IDLE on release. Same actions as PRESSED → IDLE, except bit 0 of `history` takes 1.
- **Hold counter**
  - Width $clog2(LONG_CYCLES+1).
  - Clears on entry to PRESSED and increments in PRESSED.
  - Does not count in LONG.
- **Simultaneous events:** release in the same cycle the hold counter reaches LONG_CYCLES gives release priority. No `long_pulse` is emitted and the press is recorded as short.
- **Register outputs:** all outputs are registered. No pulse lasts more than one cycle, and at most one of `press_pulse`, `long_pulse`, `release_pulse` is high in any cycle.
- **Reset values:** while `rst` is high, and on the cycle after it is asserted, all outputs are 0 and the FSM is in IDLE. Synchroniser and stable level reset to released.
- **Reset mid-press:** the press is discarded, with no release and no history update. A button still held after reset is accepted as a fresh press after the normal debounce latency.

## Timing
- Raw edge to `btn_level` change and the matching pulse: DEBOUNCE_CYCLES + 2 clocks, measured with the raw input sampled at edge 0.
- `press_pulse` is high in the same cycle `btn_level` first reads 1.
- `long_pulse` is high exactly LONG_CYCLES cycles after the `press_pulse` cycle.
- `release_pulse`, `history` and `press_count` all update in the same cycle `btn_level` first reads 0.
- Minimum accepted press width is DEBOUNCE_CYCLES cycles of stable synchronised low. Anything shorter is ignored entirely.

## Structure
- **Package `btn_pkg`:** FSM state enum (IDLE, PRESSED, LONG), HISTORY_W = 6, COUNT_W = 8, and the default constants DEBOUNCE_27M = 270000 and LONG_27M = 27000000.
- **Sub-module `sync_debounce`:** holds the synchroniser, debounce counter and stable level. It is parameterised by DEBOUNCE_CYCLES and outputs the stable level plus one-cycle rise and fall strobes.
- **Top:** holds the FSM, hold counter, history and press count.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and LONG_CYCLES = 20.
1. **Reset release:** hold `btn_n` = 1 through `rst` and for 10 cycles after → all outputs stay 0 and `history` = 000000.
2. **Short press:** drive `btn_n` low at cycle 0 for 10 cycles → `press_pulse` at cycle 6; `release_pulse` at cycle 16; `history` = 000000; `press_count` = 1; no `long_pulse`.
3. **Bounce:** toggle `btn_n` every 2 cycles for 12 cycles, then hold low → no pulse during toggling; `press_pulse` 6 cycles after the final stable low.
4. **Long press:** hold low 40 cycles → `press_pulse` at 6; `long_pulse` at 26; on release `history` = 000001. A following short press gives `history` = 000010.
5. **Release at threshold:** release timed so the accepted release lands on the hold-counter = 20 cycle → `release_pulse` only; `history` bit 0 = 0.
6. **Reset mid-press and wrap**
   - Assert `rst` one cycle while in LONG with the button held → outputs clear and no `release_pulse`. `press_pulse` recurs 6 cycles after reset deasserts.
   - Separately, 256 short presses → `press_count` wraps to 0.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the button event reader.
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
  localparam int HISTORY_W = 6;
  localparam int COUNT_W = 8;
  localparam int DEBOUNCE_27M = 270000;
  localparam int LONG_27M = 27000000;
endpackage

// File: rtl/btn_event_reader_sync_debounce.sv
// sync_debounce: two-flop synchroniser plus counter debouncer with registered edge strobes.
module sync_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_27M
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt, cnt_inc;
  logic differ, flip;
  assign differ = ~sync[1] != level;
  assign cnt_inc = cnt + 1'b1;
  assign flip = differ && cnt_inc == CMAX;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], btn_n};
      cnt <= (differ && !flip) ? cnt_inc : '0;
      level <= level ^ flip;
      rise <= flip & ~level;
      fall <= flip & level;
    end
  end
endmodule

// File: rtl/btn_event_reader.sv
// btn_event_reader: debounced button press classifier with event pulses, history and count.
module btn_event_reader
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_27M,
  parameter int LONG_CYCLES = LONG_27M
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_n,
  output logic                 btn_level,
  output logic                 press_pulse,
  output logic                 long_pulse,
  output logic                 release_pulse,
  output logic [HISTORY_W-1:0] history,
  output logic [COUNT_W-1:0]   press_count
);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);
  state_t state, nxt;
  logic level, rise, fall, press_d, long_d, rel_d;
  logic [HW-1:0] hold;
  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sd (
    .clk(clk), .rst(rst), .btn_n(btn_n), .level(level), .rise(rise), .fall(fall)
  );
  // Release is tested before the long threshold so a coincident release counts as short.
  always_comb begin
    nxt = state;
    press_d = 1'b0;
    long_d = 1'b0;
    rel_d = 1'b0;
    if (state == IDLE && rise) begin
      nxt = PRESSED;
      press_d = 1'b1;
    end else if (state != IDLE && fall) begin
      nxt = IDLE;
      rel_d = 1'b1;
    end else if (state == PRESSED && hold == HLAST) begin
      nxt = LONG;
      long_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      btn_level <= 1'b0;
      press_pulse <= 1'b0;
      long_pulse <= 1'b0;
      release_pulse <= 1'b0;
      history <= '0;
      press_count <= '0;
    end else begin
      state <= nxt;
      hold <= (state == PRESSED) ? hold + 1'b1 : '0;
      btn_level <= level;
      press_pulse <= press_d;
      long_pulse <= long_d;
      release_pulse <= rel_d;
      if (rel_d) begin
        history <= {history[HISTORY_W-2:0], state == LONG};
        press_count <= press_count + 1'b1;
      end
    end
  end
endmodule
